// File: rtl/vproc_pkg.sv
// Shared vector-processor constants: opcodes, functs, width codes, NOP word,
// instruction field positions and small field-extraction helpers.
package vproc_pkg;

    // Primary opcodes
    localparam logic [0:5] OpRAlu  = 6'b101010;
    localparam logic [0:5] OpLoad  = 6'b100000;
    localparam logic [0:5] OpStore = 6'b100001;
    localparam logic [0:5] OpBez   = 6'b100010;
    localparam logic [0:5] OpBnez  = 6'b100011;
    localparam logic [0:5] OpNop   = 6'b111100;

    // R_ALU function codes
    localparam logic [0:5] FunctVand = 6'b000001;
    localparam logic [0:5] FunctVor  = 6'b000010;
    localparam logic [0:5] FunctVxor = 6'b000011;
    localparam logic [0:5] FunctVnot = 6'b000100;
    localparam logic [0:5] FunctVmov = 6'b000101;
    localparam logic [0:5] FunctVadd = 6'b000110;

    // Element width codes (WW field)
    localparam logic [0:1] Width_8  = 2'b00;
    localparam logic [0:1] Width_16 = 2'b01;
    localparam logic [0:1] Width_32 = 2'b10;
    localparam logic [0:1] Width_64 = 2'b11;

    localparam logic [0:31] NopWord = {OpNop, 26'b0};

    // Field positions, bit 0 is the MSB
    localparam int unsigned OpMsb    = 0;
    localparam int unsigned OpLsb    = 5;
    localparam int unsigned RdMsb    = 6;
    localparam int unsigned RdLsb    = 10;
    localparam int unsigned RaMsb    = 11;
    localparam int unsigned RaLsb    = 15;
    localparam int unsigned RbMsb    = 16;
    localparam int unsigned RbLsb    = 20;
    localparam int unsigned WwMsb    = 24;
    localparam int unsigned WwLsb    = 25;
    localparam int unsigned FunctMsb = 26;
    localparam int unsigned FunctLsb = 31;
    localparam int unsigned ImmMsb   = 16;
    localparam int unsigned ImmLsb   = 31;

    typedef enum logic [0:0] {StRun, StHold} stall_state_e;

    function automatic logic [0:5] instr_op(input logic [0:31] instr);
        return instr[OpMsb:OpLsb];
    endfunction

    function automatic logic [0:4] instr_rd(input logic [0:31] instr);
        return instr[RdMsb:RdLsb];
    endfunction

    function automatic logic [0:4] instr_ra(input logic [0:31] instr);
        return instr[RaMsb:RaLsb];
    endfunction

    function automatic logic [0:4] instr_rb(input logic [0:31] instr);
        return instr[RbMsb:RbLsb];
    endfunction

    function automatic logic [0:15] instr_imm(input logic [0:31] instr);
        return instr[ImmMsb:ImmLsb];
    endfunction

endpackage

// File: rtl/vreg_file.sv
// Vector register file: three combinational read ports with write-through,
// one write port, register 0 hard-wired to zero, asynchronous clear.
module vreg_file
    import vproc_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned NREG   = 32,
    parameter int unsigned AddrW  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [0:AddrW-1]  i_raddr_a,
    input  logic [0:AddrW-1]  i_raddr_b,
    input  logic [0:AddrW-1]  i_raddr_d,
    output logic [0:DATA_W-1] o_rdata_a,
    output logic [0:DATA_W-1] o_rdata_b,
    output logic [0:DATA_W-1] o_rdata_d,
    input  logic              i_we,
    input  logic [0:AddrW-1]  i_waddr,
    input  logic [0:DATA_W-1] i_wdata
);

    logic [0:DATA_W-1] r_regs [NREG];

    // Storage: async clear, writes to register 0 dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Read ports: zero for register 0, bypass a same-cycle write
    always_comb begin
        o_rdata_a = r_regs[i_raddr_a];
        o_rdata_b = r_regs[i_raddr_b];
        o_rdata_d = r_regs[i_raddr_d];
        if (i_we && (i_waddr == i_raddr_a)) o_rdata_a = i_wdata;
        if (i_we && (i_waddr == i_raddr_b)) o_rdata_b = i_wdata;
        if (i_we && (i_waddr == i_raddr_d)) o_rdata_d = i_wdata;
        if (i_raddr_a == '0) o_rdata_a = '0;
        if (i_raddr_b == '0) o_rdata_b = '0;
        if (i_raddr_d == '0) o_rdata_d = '0;
    end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: register read, load-use / branch-operand hazard
// detection with a one-cycle stall FSM, branch resolution, ID/EX register.
module id_stage
    import vproc_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned NREG   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [0:31]       if_id_instr,
    input  logic              if_id_valid,
    input  logic              wb_we,
    input  logic [0:4]        wb_addr,
    input  logic [0:DATA_W-1] wb_data,
    output logic [0:31]       id_ex_instr,
    output logic [0:DATA_W-1] id_ex_a,
    output logic [0:DATA_W-1] id_ex_b,
    output logic [0:DATA_W-1] id_ex_d,
    output logic [0:15]       id_ex_imm,
    output logic              stall_if,
    output logic              branch_taken,
    output logic [0:15]       branch_target
);

    // Low until the first clock edge after reset release; blocks capture on that edge
    logic              r_rst_sync;
    stall_state_e      r_state;
    stall_state_e      w_state_next;
    logic [0:31]       r_instr;
    logic [0:DATA_W-1] r_a, r_b, r_d;
    logic [0:15]       r_imm;

    logic [0:5]        w_op, w_ex_op;
    logic [0:4]        w_rd, w_ra, w_rb, w_ex_rd;
    logic [0:DATA_W-1] w_rdata_a, w_rdata_b, w_rdata_d;
    logic              w_load_use, w_branch_dep, w_hazard, w_stall, w_taken, w_bubble;

    assign w_op    = instr_op(if_id_instr);
    assign w_rd    = instr_rd(if_id_instr);
    assign w_ra    = instr_ra(if_id_instr);
    assign w_rb    = instr_rb(if_id_instr);
    assign w_ex_op = instr_op(r_instr);
    assign w_ex_rd = instr_rd(r_instr);

    vreg_file #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_vreg_file (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_raddr_a (w_ra),
        .i_raddr_b (w_rb),
        .i_raddr_d (w_rd),
        .o_rdata_a (w_rdata_a),
        .o_rdata_b (w_rdata_b),
        .o_rdata_d (w_rdata_d),
        .i_we      (wb_we),
        .i_waddr   (wb_addr),
        .i_wdata   (wb_data)
    );

    // Reset-release synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 1'b0;
        else        r_rst_sync <= 1'b1;
    end

    // Hazard detection against the instruction currently in ID/EX
    always_comb begin
        w_load_use   = 1'b0;
        w_branch_dep = 1'b0;
        if ((w_ex_op == OpLoad) && (w_ex_rd != '0)) begin
            case (w_op)
                OpRAlu:        w_load_use = (w_ra == w_ex_rd) || (w_rb == w_ex_rd);
                OpLoad:        w_load_use = (w_ra == w_ex_rd);
                OpStore:       w_load_use = (w_ra == w_ex_rd) || (w_rd == w_ex_rd);
                OpBez, OpBnez: w_load_use = (w_rd == w_ex_rd);
                default:       w_load_use = 1'b0;
            endcase
        end
        if (((w_op == OpBez) || (w_op == OpBnez)) &&
            ((w_ex_op == OpRAlu) || (w_ex_op == OpLoad)) &&
            (w_ex_rd != '0) && (w_ex_rd == w_rd)) begin
            w_branch_dep = 1'b1;
        end
        w_hazard = r_rst_sync && if_id_valid && (w_load_use || w_branch_dep);
    end

    // Stall FSM next state and stall request; HOLD lasts one cycle while the bubble drains
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        case (r_state)
            StRun: begin
                w_stall = w_hazard;
                if (w_hazard) w_state_next = StHold;
            end
            StHold:  w_state_next = StRun;
            default: w_state_next = StRun;
        endcase
    end

    // Stall FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StRun;
        else        r_state <= w_state_next;
    end

    // Branch resolution; a hazard suppresses it
    always_comb begin
        w_taken = 1'b0;
        if (r_rst_sync && if_id_valid && !w_stall) begin
            if (w_op == OpBez)  w_taken = (w_rdata_d == '0);
            if (w_op == OpBnez) w_taken = (w_rdata_d != '0);
        end
        w_bubble = !if_id_valid || w_stall || w_taken;
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= NopWord;
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_imm   <= '0;
        end else if (r_rst_sync) begin
            if (w_bubble) begin
                r_instr <= NopWord;
                r_a     <= '0;
                r_b     <= '0;
                r_d     <= '0;
                r_imm   <= '0;
            end else begin
                r_instr <= if_id_instr;
                r_a     <= w_rdata_a;
                r_b     <= w_rdata_b;
                r_d     <= w_rdata_d;
                r_imm   <= instr_imm(if_id_instr);
            end
        end
    end

    assign id_ex_instr   = r_instr;
    assign id_ex_a       = r_a;
    assign id_ex_b       = r_b;
    assign id_ex_d       = r_d;
    assign id_ex_imm     = r_imm;
    assign stall_if      = w_stall;
    assign branch_taken  = w_taken;
    assign branch_target = instr_imm(if_id_instr);

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic
// checked against an instruction-level reference model.
module tb_id_stage;

    localparam logic [5:0] OP_RALU  = 6'b101010;
    localparam logic [5:0] OP_LOAD  = 6'b100000;
    localparam logic [5:0] OP_STORE = 6'b100001;
    localparam logic [5:0] OP_BEZ   = 6'b100010;
    localparam logic [5:0] OP_BNEZ  = 6'b100011;
    localparam logic [5:0] OP_NOP   = 6'b111100;
    localparam logic [31:0] NOP_WORD = 32'hF000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:31] if_id_instr = '0;
    logic        if_id_valid = 1'b0;
    logic        wb_we = 1'b0;
    logic [0:4]  wb_addr = '0;
    logic [0:63] wb_data = '0;
    logic [0:31] id_ex_instr;
    logic [0:63] id_ex_a, id_ex_b, id_ex_d;
    logic [0:15] id_ex_imm;
    logic        stall_if, branch_taken;
    logic [0:15] branch_target;

    id_stage #(
        .DATA_W (64),
        .NREG   (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .wb_we         (wb_we),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .id_ex_instr   (id_ex_instr),
        .id_ex_a       (id_ex_a),
        .id_ex_b       (id_ex_b),
        .id_ex_d       (id_ex_d),
        .id_ex_imm     (id_ex_imm),
        .stall_if      (stall_if),
        .branch_taken  (branch_taken),
        .branch_target (branch_target)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [63:0] m_rf [32];
    logic [31:0] m_ex_instr;
    logic [63:0] m_ex_a, m_ex_b, m_ex_d;
    logic [15:0] m_ex_imm;
    bit          m_active;
    bit          last_stall;
    bit          obs_stall, obs_taken;
    logic [15:0] obs_target;

    function automatic int f_rd(input logic [31:0] i); return int'(i[25:21]); endfunction
    function automatic int f_ra(input logic [31:0] i); return int'(i[20:16]); endfunction
    function automatic int f_rb(input logic [31:0] i); return int'(i[15:11]); endfunction

    function automatic logic [31:0] mk_r(input logic [5:0] op, input int rd, input int ra,
                                         input int rb, input logic [5:0] funct);
        return {op, 5'(rd), 5'(ra), 5'(rb), 3'b000, 2'b11, funct};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input int rd, input int ra,
                                         input logic [15:0] imm);
        return {op, 5'(rd), 5'(ra), imm};
    endfunction

    function automatic logic [63:0] rd_val(input int r);
        if (r == 0) return 64'd0;
        if (wb_we && (int'(wb_addr) == r)) return wb_data;
        return m_rf[r];
    endfunction

    function automatic bit model_hazard(input logic [31:0] ins, input bit v);
        logic [5:0] op, ex_op;
        int rd, ra, rb, ex_rd;
        bit is_br;
        op = ins[31:26];
        ex_op = m_ex_instr[31:26];
        rd = f_rd(ins); ra = f_ra(ins); rb = f_rb(ins);
        ex_rd = f_rd(m_ex_instr);
        is_br = (op == OP_BEZ) || (op == OP_BNEZ);
        if (!m_active || !v) return 1'b0;
        if (ex_op == OP_LOAD && ex_rd != 0) begin
            if (op == OP_RALU && (ra == ex_rd || rb == ex_rd)) return 1'b1;
            if ((op == OP_LOAD || op == OP_STORE) && ra == ex_rd) return 1'b1;
            if ((op == OP_STORE || is_br) && rd == ex_rd) return 1'b1;
        end
        if (is_br && (ex_op == OP_RALU || ex_op == OP_LOAD) && ex_rd != 0 && ex_rd == rd)
            return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
        m_ex_instr = NOP_WORD;
        m_ex_a = 0; m_ex_b = 0; m_ex_d = 0; m_ex_imm = 0;
        m_active = 1'b0;
        last_stall = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_instr"}, id_ex_instr, NOP_WORD);
        check_eq({tag, "_a"}, id_ex_a, 0);
        check_eq({tag, "_b"}, id_ex_b, 0);
        check_eq({tag, "_d"}, id_ex_d, 0);
        check_eq({tag, "_imm"}, id_ex_imm, 0);
        check_eq({tag, "_stall"}, stall_if, 0);
        check_eq({tag, "_taken"}, branch_taken, 0);
    endtask

    // One cycle: drive at posedge+1, check combinational outputs at negedge,
    // advance the model on the posedge, check ID/EX at posedge+1.
    task automatic step(input logic [31:0] ins, input bit v, input bit we, input int wa,
                        input logic [63:0] wd);
        bit exp_h, exp_t;
        logic [63:0] va, vb, vd;
        logic [5:0] op;
        if_id_instr = ins;
        if_id_valid = v;
        wb_we = we;
        wb_addr = 5'(wa);
        wb_data = wd;
        #4;
        op = ins[31:26];
        exp_h = model_hazard(ins, v);
        va = rd_val(f_ra(ins));
        vb = rd_val(f_rb(ins));
        vd = rd_val(f_rd(ins));
        exp_t = m_active && v && !exp_h &&
                ((op == OP_BEZ && vd == 0) || (op == OP_BNEZ && vd != 0));
        obs_stall = stall_if;
        obs_taken = branch_taken;
        obs_target = branch_target;
        check_eq("stall_if", stall_if, exp_h);
        check_eq("branch_taken", branch_taken, exp_t);
        if (exp_t) check_eq("branch_target", branch_target, ins[15:0]);
        last_stall = exp_h;
        @(posedge clk);
        if (!m_active || !v || exp_h || exp_t) begin
            m_ex_instr = NOP_WORD;
            m_ex_a = 0; m_ex_b = 0; m_ex_d = 0; m_ex_imm = 0;
        end else begin
            m_ex_instr = ins;
            m_ex_a = va; m_ex_b = vb; m_ex_d = vd; m_ex_imm = ins[15:0];
        end
        if (we && wa != 0) m_rf[wa] = wd;
        m_active = 1'b1;
        #1;
        check_eq("id_ex_instr", id_ex_instr, m_ex_instr);
        check_eq("id_ex_a", id_ex_a, m_ex_a);
        check_eq("id_ex_b", id_ex_b, m_ex_b);
        check_eq("id_ex_d", id_ex_d, m_ex_d);
        check_eq("id_ex_imm", id_ex_imm, m_ex_imm);
    endtask

    initial begin
        logic [31:0] ins;
        logic [5:0] ops [6];
        bit v;
        ops[0] = OP_RALU; ops[1] = OP_LOAD; ops[2] = OP_STORE;
        ops[3] = OP_BEZ;  ops[4] = OP_BNEZ; ops[5] = OP_NOP;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // First edge after release must not capture, second one does
        ins = mk_r(OP_RALU, 1, 0, 0, 6'b000110);
        step(ins, 1, 0, 0, 0);
        check_eq("sync_first_edge", id_ex_instr, NOP_WORD);
        step(ins, 1, 0, 0, 0);
        check_eq("sync_second_edge", id_ex_instr, ins);

        // Writeback then read through rA
        step(NOP_WORD, 1, 1, 5, 64'h0123_4567_89AB_CDEF);
        step(mk_r(OP_RALU, 1, 5, 0, 6'b000110), 1, 0, 0, 0);
        check_eq("vadd_a", id_ex_a, 64'h0123_4567_89AB_CDEF);
        check_eq("vadd_b", id_ex_b, 0);

        // Load-use stall
        step(mk_i(OP_LOAD, 3, 1, 16'h0010), 1, 0, 0, 0);
        ins = mk_r(OP_RALU, 2, 3, 1, 6'b000001);
        step(ins, 1, 0, 0, 0);
        check_eq("loaduse_stall", obs_stall, 1);
        check_eq("loaduse_bubble", id_ex_instr, NOP_WORD);
        step(ins, 1, 0, 0, 0);
        check_eq("loaduse_release", obs_stall, 0);
        check_eq("loaduse_issue", id_ex_instr, ins);

        // BEZ taken on zero register, BNEZ not taken
        step(NOP_WORD, 1, 1, 7, 0);
        step(mk_i(OP_BEZ, 7, 0, 16'h0040), 1, 0, 0, 0);
        check_eq("bez_taken", obs_taken, 1);
        check_eq("bez_target", obs_target, 16'h0040);
        check_eq("bez_bubble", id_ex_instr, NOP_WORD);
        step(mk_i(OP_BNEZ, 7, 0, 16'h0044), 1, 0, 0, 0);
        check_eq("bnez_not_taken", obs_taken, 0);

        // Branch-operand stall, then resolve on the freshly written R4
        step(mk_r(OP_RALU, 4, 1, 2, 6'b000110), 1, 0, 0, 0);
        ins = mk_i(OP_BNEZ, 4, 0, 16'h0080);
        step(ins, 1, 0, 0, 0);
        check_eq("brdep_stall", obs_stall, 1);
        step(ins, 1, 1, 4, 64'h5);
        check_eq("brdep_release", obs_stall, 0);
        check_eq("brdep_taken", obs_taken, 1);

        // Write-through and register 0
        step(mk_r(OP_RALU, 1, 9, 0, 6'b000010), 1, 1, 9, 64'hFF);
        check_eq("wt_a", id_ex_a, 64'hFF);
        step(NOP_WORD, 1, 1, 0, 64'hDEAD);
        step(mk_r(OP_RALU, 0, 0, 0, 6'b000110), 1, 0, 0, 0);
        check_eq("r0_a", id_ex_a, 0);
        check_eq("r0_b", id_ex_b, 0);

        // Reset in the middle of a stall
        step(mk_i(OP_LOAD, 6, 1, 16'h0000), 1, 0, 0, 0);
        if_id_instr = mk_r(OP_RALU, 2, 6, 0, 6'b000110);
        if_id_valid = 1'b1;
        wb_we = 1'b0;
        #4;
        check_eq("midstall_stall", stall_if, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midstall_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ins = mk_r(OP_RALU, 1, 5, 9, 6'b000110);
        step(ins, 1, 0, 0, 0);
        step(ins, 1, 0, 0, 0);
        check_eq("rf_cleared_a", id_ex_a, 0);
        check_eq("rf_cleared_b", id_ex_b, 0);

        // Randomized traffic on a small register window to force collisions
        ins = NOP_WORD;
        v = 1'b1;
        for (int n = 0; n < 400; n++) begin
            logic [5:0] op;
            logic [63:0] wd;
            if (!last_stall) begin
                op = ops[$urandom_range(0, 5)];
                if (op == OP_RALU)
                    ins = mk_r(op, $urandom_range(0, 7), $urandom_range(0, 7),
                               $urandom_range(0, 7), 6'($urandom_range(1, 6)));
                else
                    ins = mk_i(op, $urandom_range(0, 7), $urandom_range(0, 7),
                               16'($urandom));
                v = ($urandom_range(0, 9) != 0);
            end
            wd = ($urandom_range(0, 2) == 0) ? 64'd0 : {$urandom, $urandom};
            step(ins, v, 1'($urandom_range(0, 1)), $urandom_range(0, 7), wd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter DATA_W, 64, vector register width; bit 0 is the MSB, as in the ALU.
REQ-002 Parameter NREG, 32, number of vector registers (5-bit address).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert and active-low.
REQ-005 if_id_instr  in  [0:31]  fetched instruction: opcode [0:5], rD [6:10], rA [11:15], rB [16:20], WW [24:25], funct [26:31], imm [16:31].
REQ-006 if_id_valid  in  1  if_id_instr holds a real instruction.
REQ-007 wb_we / wb_addr / wb_data  in  1 / [0:4] / [0:63]  writeback port into the register file.
REQ-008 id_ex_instr / id_ex_a / id_ex_b / id_ex_d  out  [0:31] / [0:63] x3  registered ID/EX payload: rA, rB and rD contents.
REQ-009 id_ex_imm  out  [0:15]  registered immediate.
REQ-010 stall_if  out  1  combinational request for IF to hold the PC and IF/ID.
REQ-011 branch_taken / branch_target  out  1 / [0:15]  combinational branch-resolution result.

Function
REQ-012 Opcodes decoded: R_ALU 101010, LOAD 100000, STORE 100001, BEZ 100010, BNEZ 100011, NOP 111100; any other opcode is treated as NOP.
REQ-013 Register reads are combinational on rA, rB and rD.
REQ-014 Register 0 reads as zero, and writes to it are ignored.
REQ-015 Write-through: a same-cycle write to a register being read returns wb_data.
REQ-016 Latency: one cycle from IF/ID to the ID/EX outputs when no stall is asserted.
REQ-017 Load-use hazard: stall_if=1 and a bubble is inserted when id_ex_instr is a LOAD, its rD is non-zero and equals the current rA/rB (R_ALU), rA (LOAD/STORE), or rD (STORE/BEZ/BNEZ).
REQ-018 Branch-operand hazard: stall_if=1 and a bubble is inserted when the current instruction is BEZ/BNEZ and id_ex_instr is R_ALU or LOAD whose non-zero rD equals the branch rD.
REQ-019 Bubble definition: id_ex_instr is loaded with the NOP word (111100 followed by 26 zeros), and id_ex_a/b/d/imm are loaded with zero.
REQ-020 Stall FSM states: RUN and HOLD.
REQ-021 RUN to HOLD when a hazard is detected; HOLD to RUN after exactly one cycle.
REQ-022 In HOLD the hazard is re-evaluated against the bubble, so it clears.
REQ-023 Branch resolution happens only when not stalled and if_id_valid=1.
REQ-024 BEZ is taken when the rD value is all zero; BNEZ is taken otherwise; branch_target = imm.
REQ-025 A taken branch forwards a bubble to ID/EX in the next cycle; IF discards the wrong-path instruction.
REQ-026 When if_id_valid=0, a bubble is loaded and no hazard or branch is raised.
REQ-027 Simultaneous events: a hazard takes priority over branch resolution.
REQ-028 Simultaneous events: writeback is always accepted, including during a stall.

Reset
REQ-029 While rst_n=0: FSM=RUN, id_ex_instr=NOP word, id_ex_a/b/d/imm=0, stall_if=0, branch_taken=0.
REQ-030 The register file contents are cleared to zero asynchronously.
REQ-031 Deassertion of reset is synchronised internally; the first capture occurs on the second rising edge after rst_n rises.

Structure
REQ-032 Shared package vproc_pkg holds the opcode, funct, width-code (Width_8 to Width_64) and NOP-word constants, and the instruction field index constants.
REQ-033 Sub-module vreg_file: NREG x DATA_W, three read ports, one write port, async clear, write-through; it is instantiated once.

Verification
REQ-034 Write R5=0x0123456789ABCDEF via WB, then R_ALU VADD rA=5, rB=0 -> next cycle id_ex_a=0x0123456789ABCDEF, id_ex_b=0.
REQ-035 LOAD rD=3, then immediately VAND rA=3 -> stall_if=1 for one cycle, one NOP word in ID/EX, then VAND issues.
REQ-036 R7=0, then BEZ rD=7 imm=0x0040 -> branch_taken=1, branch_target=0x0040, bubble next cycle.
REQ-037 R7=0, then BNEZ rD=7 -> branch_taken=0.
REQ-038 VADD rD=4, then immediately BNEZ rD=4 -> one-cycle stall, then branch resolved on the new R4.
REQ-039 WB write R9=0xFF together with a read of rA=9 -> id_ex_a=0xFF.
REQ-040 WB write to R0 -> later reads of R0 return 0.
REQ-041 rst_n pulsed low mid-stall -> all outputs return to reset values immediately, and the FSM is in RUN.
